// File: rtl/add_block_seq.sv
// Sequencer for the shared packed adder: runs multi-beat lane accumulations,
// optionally folds the hi lane into the lo lane, and hands the result out.

module add_block_seq_lane #(
    parameter int LANE_W = 32
) (
    input  logic              sel_acc,
    input  logic              sel_fold,
    input  logic [LANE_W-1:0] acc_lane,
    input  logic [LANE_W-1:0] in_lane,
    input  logic [LANE_W-1:0] fold_a,
    input  logic [LANE_W-1:0] fold_b,
    output logic [LANE_W-1:0] a,
    output logic [LANE_W-1:0] b
);
    always_comb begin
        a = '0;
        b = '0;
        if (sel_acc) begin
            a = acc_lane;
            b = in_lane;
        end else if (sel_fold) begin
            a = fold_a;
            b = fold_b;
        end
    end
endmodule

module add_block_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             mode_3_i,
    input  logic             fold_i,
    input  logic             abort_i,
    output logic             busy_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [63:0]      in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [63:0]      out_data_o,
    output logic [63:0]      add_a_o,
    output logic [63:0]      add_b_o,
    output logic             add_mode_3_o,
    input  logic [63:0]      add_sums_i
);
    localparam int NUM_LANES = 2;
    localparam int LANE_W    = 32;

    typedef enum logic [1:0] {IDLE, ACC, FOLD, DONE} state_t;

    state_t             state, state_n;
    logic [63:0]        acc, acc_n;
    logic [LEN_W-1:0]   cnt, cnt_n;
    logic               mode_q, mode_n;
    logic               fold_q, fold_n;

    logic [NUM_LANES-1:0][LANE_W-1:0] acc_l, in_l, a_l, b_l;
    logic st_acc, st_fold;

    assign acc_l   = acc;
    assign in_l    = in_data_i;
    assign st_acc  = (state == ACC);
    assign st_fold = (state == FOLD);

    // Fold only feeds lane 0 (hi + lo); lane 1 sees zeros so the upper half clears.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        add_block_seq_lane #(.LANE_W(LANE_W)) u_lane (
            .sel_acc  (st_acc),
            .sel_fold (st_fold),
            .acc_lane (acc_l[l]),
            .in_lane  (in_l[l]),
            .fold_a   (l == 0 ? acc_l[1] : '0),
            .fold_b   (l == 0 ? acc_l[0] : '0),
            .a        (a_l[l]),
            .b        (b_l[l])
        );
    end

    assign add_a_o    = a_l;
    assign add_b_o    = b_l;
    assign out_data_o = acc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
            fold_q <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            mode_q <= mode_n;
            fold_q <= fold_n;
        end
    end

    always_comb begin
        state_n      = state;
        acc_n        = acc;
        cnt_n        = cnt;
        mode_n       = mode_q;
        fold_n       = fold_q;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        add_mode_3_o = 1'b0;
        busy_o       = (state != IDLE);

        case (state)
            IDLE: begin
                if (start_i) begin
                    mode_n  = mode_3_i;
                    fold_n  = fold_i;
                    cnt_n   = len_i;
                    acc_n   = '0;
                    state_n = (len_i != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                in_ready_o   = !abort_i;
                add_mode_3_o = mode_q;
                if (in_valid_i && in_ready_o) begin
                    acc_n = add_sums_i;
                    cnt_n = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1))
                        state_n = fold_q ? FOLD : DONE;
                end
            end
            FOLD: begin
                acc_n   = add_sums_i;
                state_n = DONE;
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Abort overrides any transition chosen above, including a start in IDLE.
        if (abort_i) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
        end
    end
endmodule
